// File: rtl/uart_cmd_responder.sv
// ============================================================================
// Module   : uart_cmd_responder
// Brief    : UART byte-stream command decoder giving a debugger single 32-bit
//            register reads/writes on a ready-handshaked bus.
//            Optional frame checksums enabled by UART_CMD_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_responder #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT     = 100000,
  parameter int BUS_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_err,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic              bus_wen,
  output logic              bus_ren,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ready,
  output logic              busy
);

  localparam logic [7:0] c_CMD_WR = 8'h57;
  localparam logic [7:0] c_CMD_RD = 8'h52;
  localparam logic [7:0] c_ACK    = 8'h06;
  localparam logic [7:0] c_NAK    = 8'h15;
  localparam int         c_TO_W   = $clog2(TIMEOUT + 1);
  localparam int         c_BT_W   = $clog2(BUS_TIMEOUT + 1);
  localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT - 1);
  localparam logic [c_BT_W-1:0] c_BT_MAX = c_BT_W'(BUS_TIMEOUT - 1);
`ifdef UART_CMD_CHECKSUM_EN
  localparam logic [2:0] c_CS_LEN = 3'd1;
`else
  localparam logic [2:0] c_CS_LEN = 3'd0;
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GET_ADDR  = 3'd1,
    S_GET_DATA  = 3'd2,
    S_BUS_ACC   = 3'd3,
    S_SEND      = 3'd4,
    S_SEND_WAIT = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_is_wr, w_is_wr_nxt;
  logic [2:0]          r_cnt, w_cnt_nxt;
  logic [c_TO_W-1:0]   r_to_cnt, w_to_nxt;
  logic [c_BT_W-1:0]   r_bt_cnt, w_bt_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [31:0]         r_wdata, w_wdata_nxt;
  logic [31:0]         r_resp, w_resp_nxt;
  logic [2:0]          r_len, w_len_nxt;
  logic [2:0]          r_idx, w_idx_nxt;
  logic                r_tx_start, w_tx_start_nxt;
  logic [2:0]          w_total;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]          r_csum, w_csum_nxt;
  logic [7:0]          w_resp_cs;
  logic [2:0]          w_last;
`endif

  assign w_total   = r_len + c_CS_LEN;
  assign busy      = (r_state != S_IDLE);
  assign tx_start  = r_tx_start;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_wen   = (r_state == S_BUS_ACC) &&  r_is_wr;
  assign bus_ren   = (r_state == S_BUS_ACC) && !r_is_wr;

`ifdef UART_CMD_CHECKSUM_EN
  // Trailing request byte index: after 4 data bytes for a write, right after addr for a read.
  assign w_last    = r_is_wr ? 3'd4 : 3'd0;
  assign w_resp_cs = (r_len == 3'd1) ? r_resp[7:0]
                   : (r_resp[7:0] ^ r_resp[15:8] ^ r_resp[23:16] ^ r_resp[31:24]);
  assign tx_data   = (r_idx == r_len) ? w_resp_cs : r_resp[{r_idx[1:0], 3'b000} +: 8];
`else
  assign tx_data   = r_resp[{r_idx[1:0], 3'b000} +: 8];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_wr    <= 1'b0;
      r_cnt      <= '0;
      r_to_cnt   <= '0;
      r_bt_cnt   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_resp     <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_tx_start <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_is_wr    <= w_is_wr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_to_cnt   <= w_to_nxt;
      r_bt_cnt   <= w_bt_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_resp     <= w_resp_nxt;
      r_len      <= w_len_nxt;
      r_idx      <= w_idx_nxt;
      r_tx_start <= w_tx_start_nxt;
`ifdef UART_CMD_CHECKSUM_EN
      r_csum     <= w_csum_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_is_wr_nxt    = r_is_wr;
    w_cnt_nxt      = r_cnt;
    w_to_nxt       = '0;
    w_bt_nxt       = '0;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_resp_nxt     = r_resp;
    w_len_nxt      = r_len;
    w_idx_nxt      = r_idx;
    w_tx_start_nxt = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    w_csum_nxt     = r_csum;
`endif
    case (r_state)
      S_IDLE: begin
        w_idx_nxt = '0;
        if (!rx_err && rx_valid) begin
`ifdef UART_CMD_CHECKSUM_EN
          w_csum_nxt = rx_data;
`endif
          if (rx_data == c_CMD_WR || rx_data == c_CMD_RD) begin
            w_is_wr_nxt = (rx_data == c_CMD_WR);
            w_state_nxt = S_GET_ADDR;
          end else begin
            w_resp_nxt  = {24'd0, c_NAK};
            w_len_nxt   = 3'd1;
            w_state_nxt = S_SEND;
          end
        end
      end
      S_GET_ADDR: begin
        if (rx_err) begin
          w_state_nxt = S_IDLE;
        end else if (rx_valid) begin
          w_addr_nxt = ADDR_W'(rx_data);
          w_cnt_nxt  = '0;
`ifdef UART_CMD_CHECKSUM_EN
          w_csum_nxt  = r_csum ^ rx_data;
          w_state_nxt = S_GET_DATA;
`else
          w_state_nxt = r_is_wr ? S_GET_DATA : S_BUS_ACC;
`endif
        end else if (r_to_cnt == c_TO_MAX) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
      end
      S_GET_DATA: begin
        if (rx_err) begin
          w_state_nxt = S_IDLE;
        end else if (rx_valid) begin
`ifdef UART_CMD_CHECKSUM_EN
          if (r_cnt == w_last) begin
            if (rx_data == r_csum) begin
              w_state_nxt = S_BUS_ACC;
            end else begin
              w_resp_nxt  = {24'd0, c_NAK};
              w_len_nxt   = 3'd1;
              w_state_nxt = S_SEND;
            end
          end else begin
            w_wdata_nxt[{r_cnt[1:0], 3'b000} +: 8] = rx_data;
            w_csum_nxt = r_csum ^ rx_data;
            w_cnt_nxt  = r_cnt + 3'd1;
          end
`else
          w_wdata_nxt[{r_cnt[1:0], 3'b000} +: 8] = rx_data;
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt == 3'd3) w_state_nxt = S_BUS_ACC;
`endif
        end else if (r_to_cnt == c_TO_MAX) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
      end
      S_BUS_ACC: begin
        if (bus_ready) begin
          w_resp_nxt  = r_is_wr ? {24'd0, c_ACK} : bus_rdata;
          w_len_nxt   = r_is_wr ? 3'd1 : 3'd4;
          w_state_nxt = S_SEND;
        end else if (r_bt_cnt == c_BT_MAX) begin
          w_resp_nxt  = {24'd0, c_NAK};
          w_len_nxt   = 3'd1;
          w_state_nxt = S_SEND;
        end else begin
          w_bt_nxt = r_bt_cnt + 1'b1;
        end
      end
      S_SEND: begin
        // Request is raised only while the transmitter is idle and dropped once it accepts.
        if (r_tx_start && tx_busy) begin
          w_state_nxt = S_SEND_WAIT;
        end else begin
          w_tx_start_nxt = !tx_busy;
        end
      end
      S_SEND_WAIT: begin
        if (!tx_busy) begin
          w_idx_nxt   = r_idx + 3'd1;
          w_state_nxt = (r_idx + 3'd1 == w_total) ? S_IDLE : S_SEND;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Host-facing command endpoint at the far end of the UART link.
- Consumes received bytes from the byte-level UART (received strobe plus rx_byte) and decodes a small read/write command protocol.
- Performs single 32-bit transfers on a simple ready-handshaked register bus, then returns the response bytes through the UART transmit side (transmit, tx_byte, tx_busy).
- Gives the off-chip debugger register access to the SoC.

Parameters:
ADDR_W, 8, bus address width; the address byte is zero-extended to ADDR_W.
TIMEOUT, 100000, maximum clk cycles between bytes of one frame before the frame is abandoned.
BUS_TIMEOUT, 1024, maximum clk cycles to wait for bus_ready.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-high reset.
rx_valid  in  1  one-cycle strobe: rx_data holds a newly received byte.
rx_data  in  8  received byte.
rx_err  in  1  one-cycle strobe: framing error on the link.
tx_start  out  1  request to send tx_data; level, held until tx_busy is seen high.
tx_data  out  8  byte to send; stable while tx_start=1.
tx_busy  in  1  transmitter active.
bus_addr  out  ADDR_W  transfer address.
bus_wdata  out  32  write data.
bus_wen  out  1  write request, held until bus_ready.
bus_ren  out  1  read request, held until bus_ready.
bus_rdata  in  32  read data, valid when bus_ready=1.
bus_ready  in  1  transfer complete.
busy  out  1  frame in progress (state != IDLE).

Behaviour:
- Reset values: all outputs 0, state IDLE, byte counter 0, timeout counters 0, data register 0.
- Protocol, all multi-byte fields LSB first:
  - Write frame: 0x57, addr, d0..d3. Response: 0x06.
  - Read frame: 0x52, addr. Response: r0..r3.
  - Any other first byte: response 0x15 (NAK) and return to IDLE.
- States: IDLE, GET_ADDR, GET_DATA, BUS_ACC, SEND, SEND_WAIT.
- IDLE:
  - rx_valid with 0x57 or 0x52: latch the command, go to GET_ADDR.
  - rx_valid with any other value: load NAK into the response buffer (length 1), go to SEND.
- GET_ADDR:
  - rx_valid: latch bus_addr.
  - Next state is GET_DATA for a write (byte counter = 0), BUS_ACC for a read.
- GET_DATA:
  - Each rx_valid shifts the byte into bus_wdata[8*cnt +: 8].
  - After the 4th byte, go to BUS_ACC.
- BUS_ACC:
  - Assert bus_wen (write) or bus_ren (read) from the first cycle in the state.
  - On bus_ready, deassert the request the same edge and latch bus_rdata for a read.
  - Response buffer: ACK (length 1) for a write, the 4 data bytes for a read. Then go to SEND.
  - If BUS_TIMEOUT cycles pass without bus_ready: drop the request and respond NAK.
- SEND:
  - Wait for tx_busy=0, then drive tx_start=1 with tx_data = current byte.
  - On tx_busy=1, drop tx_start and go to SEND_WAIT.
- SEND_WAIT:
  - On tx_busy=0, advance the byte index.
  - If more bytes remain, go to SEND; otherwise go to IDLE.
- Inter-byte timeout:
  - The counter resets on every rx_valid and counts in GET_ADDR and GET_DATA.
  - Reaching TIMEOUT returns to IDLE silently: no response, no bus access.
- rx_err in any receive state (IDLE, GET_ADDR, GET_DATA): abort to IDLE silently, no response.
- rx_valid arriving in BUS_ACC, SEND or SEND_WAIT is discarded (half-duplex command/response).
- rx_valid and rx_err in the same cycle: rx_err wins.
- No bus access is issued until the frame is complete; a partial frame never touches the bus.
- Reset mid-frame: immediate return to reset values, including dropping tx_start and bus requests.

Optional Feature:
Macro UART_CMD_CHECKSUM_EN.
- Defined:
  - Each request frame carries one extra trailing byte equal to the XOR of all preceding frame bytes.
  - The checksum is checked before BUS_ACC; a mismatch responds NAK with no bus access.
  - Each response is followed by a checksum byte equal to the XOR of the response bytes. For an ACK-only response this is 0x06.
- Undefined: no checksum bytes in either direction; frames are exactly as above.

Test Plan:
- Write 0x57,0x10,0x78,0x56,0x34,0x12 -> one bus_wen pulse-hold with bus_addr=0x10, bus_wdata=0x12345678; response byte 0x06.
- Read 0x52,0x20 with bus_rdata=0xDEADBEEF, bus_ready after 3 cycles -> bus_ren high for 3 cycles; response bytes EF,BE,AD,DE in order; each tx_start waits for tx_busy=0.
- Unknown byte 0x41 -> response 0x15, no bus activity, busy returns to 0.
- Send 0x57,0x10,0x01, then stall TIMEOUT cycles -> return to IDLE, no bus_wen, no tx_start; a following valid read frame works normally.
- rx_err after the address byte of a write -> silent abort; bus_ready held 0 through BUS_TIMEOUT on the next read -> response 0x15.
- With UART_CMD_CHECKSUM_EN: read 0x52,0x20,0x72 -> data plus checksum byte; wrong checksum 0x00 -> 0x15 (NAK) and checksum byte 0x15, no bus_ren.
